// File: rtl/pipe_ctrl_if.sv
// ============================================================================
// pipe_ctrl_if : hazard-control bus between hazard manager and pipe_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

interface pipe_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             stall;
   logic             flush;
   logic             stop;
   logic             enPC;
   logic             enFD;
   logic             clrFD;
   logic             enDE;
   logic             clrDE;
   logic             enEM;
   logic             enMW;
   logic             halted;
   logic             deadlock;
   logic [CNT_W-1:0] stallCnt;
   logic [CNT_W-1:0] flushCnt;

   modport master (
      output stall, flush, stop,
      input  enPC, enFD, clrFD, enDE, clrDE, enEM, enMW,
      input  halted, deadlock, stallCnt, flushCnt
   );

   modport slave (
      input  stall, flush, stop,
      output enPC, enFD, clrFD, enDE, clrDE, enEM, enMW,
      output halted, deadlock, stallCnt, flushCnt
   );
endinterface

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : per-stage enable/clear strobes, stop/drain/halt FSM, watchdog
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl #(
   parameter int DRAIN_CYCLES = 3,
   parameter int STALL_LIMIT  = 16,
   parameter int CNT_W        = 32
) (
   input  wire logic  clk,
   input  wire logic  rst_n,
   pipe_ctrl_if.slave hz
);
   localparam int DW = $clog2(DRAIN_CYCLES + 1);
   localparam int RW = $clog2(STALL_LIMIT + 1);
   localparam logic [DW-1:0] c_drain_last = DW'(DRAIN_CYCLES - 1);
   localparam logic [RW-1:0] c_run_limit  = RW'(STALL_LIMIT);

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_DRAIN  = 2'd1,
      S_HALTED = 2'd2,
      S_RESUME = 2'd3
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [DW-1:0]     r_drain_cnt, w_drain_cnt_nxt;
   logic [RW-1:0]     r_run_len, w_run_len_nxt;
   logic              r_deadlock;
   logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;
   logic              w_stall_inc, w_flush_inc;
   logic              w_en_pc, w_en_fd, w_clr_fd, w_en_de, w_clr_de, w_en_em, w_en_mw;
   logic              w_halted;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_RUN;
         r_drain_cnt <= '0;
         r_run_len   <= '0;
         r_deadlock  <= 1'b0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_drain_cnt <= w_drain_cnt_nxt;
         r_run_len   <= w_run_len_nxt;
         r_deadlock  <= r_deadlock | (w_run_len_nxt == c_run_limit);
         if (w_stall_inc) r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_flush_inc) r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_drain_cnt_nxt = r_drain_cnt;
      w_stall_inc     = 1'b0;
      w_flush_inc     = 1'b0;
      w_halted        = 1'b0;
      w_en_pc         = 1'b1;
      w_en_fd         = 1'b1;
      w_clr_fd        = 1'b0;
      w_en_de         = 1'b1;
      w_clr_de        = 1'b0;
      w_en_em         = 1'b1;
      w_en_mw         = 1'b1;
      case (r_state)
         S_RUN: begin
            if (hz.stop) begin
               // Entry cycle already freezes the front end like DRAIN
               w_en_pc         = 1'b0;
               w_en_fd         = 1'b0;
               w_clr_de        = 1'b1;
               w_state_nxt     = S_DRAIN;
               w_drain_cnt_nxt = '0;
            end else if (hz.stall) begin
               w_en_pc     = 1'b0;
               w_en_fd     = 1'b0;
               w_clr_de    = 1'b1;
               w_stall_inc = 1'b1;
            end else if (hz.flush) begin
               w_clr_fd    = 1'b1;
               w_flush_inc = 1'b1;
            end
         end
         S_DRAIN: begin
            w_en_pc         = 1'b0;
            w_en_fd         = 1'b0;
            w_clr_de        = 1'b1;
            w_drain_cnt_nxt = r_drain_cnt + 1'b1;
            if (!hz.stop)
               w_state_nxt = S_RESUME;
            else if (r_drain_cnt == c_drain_last)
               w_state_nxt = S_HALTED;
         end
         S_HALTED: begin
            w_en_pc  = 1'b0;
            w_en_fd  = 1'b0;
            w_en_de  = 1'b0;
            w_en_em  = 1'b0;
            w_en_mw  = 1'b0;
            w_halted = 1'b1;
            if (!hz.stop) w_state_nxt = S_RESUME;
         end
         S_RESUME: begin
            // Instruction fetched before the halt is stale; drop it
            w_clr_fd    = 1'b1;
            w_state_nxt = S_RUN;
         end
         default: w_state_nxt = S_RUN;
      endcase
   end

   always_comb begin
      w_run_len_nxt = '0;
      if (r_state == S_RUN && hz.stall)
         w_run_len_nxt = (r_run_len == c_run_limit) ? r_run_len : r_run_len + 1'b1;
   end

   assign hz.enPC     = w_en_pc;
   assign hz.enFD     = w_en_fd;
   assign hz.clrFD    = w_clr_fd;
   assign hz.enDE     = w_en_de;
   assign hz.clrDE    = w_clr_de;
   assign hz.enEM     = w_en_em;
   assign hz.enMW     = w_en_mw;
   assign hz.halted   = w_halted;
   assign hz.deadlock = r_deadlock;
   assign hz.stallCnt = r_stall_cnt;
   assign hz.flushCnt = r_flush_cnt;

endmodule

`default_nettype wire
